// File: rtl/image_pipe_xform_fifo.sv
// Image pipe stage: per-frame selectable per-channel transform, DEPTH-entry FIFO,
// registered output toward the ipm with busy backpressure, frame counting and overflow flag.
module image_pipe_xform_fifo #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 8,
  parameter int DEPTH       = 16,
  parameter int BUSY_MARGIN = 2,
  parameter int FCNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*CH_W-1:0] image_pipe_data_in,
  input  logic                   image_pipe_valid_in,
  input  logic                   image_pipe_end_in,
  output logic                   image_pipe_busy_out,
  output logic [NUM_CH*CH_W-1:0] ipm_data_out,
  output logic                   ipm_valid_out,
  output logic                   ipm_end_out,
  input  logic                   ipm_busy_in,
  input  logic [1:0]             cfg_mode,
  input  logic [CH_W:0]          cfg_offset,
  output logic [FCNT_W-1:0]      frame_cnt,
  output logic                   ovf_sticky,
  input  logic                   ovf_clr,
  output logic                   dbg_state_o
);

  localparam int DW = NUM_CH * CH_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CH_W-1:0] MAXV = '1;

  // Handshake: input pixels are taken on every posedge with valid_in=1 (busy_out is
  // advisory only); an output transfer completes on a posedge with valid_out=1 and busy_in=0.

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_IN_FRAME = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CH_W:0]     off_q, off_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [1:0]            mode_eff;
  logic [CH_W:0]         off_eff;
  logic [CH_W-1:0]       ch;
  logic signed [CH_W+1:0] sum;
  logic [DW-1:0]         xf_data_d, xf_data_q;
  logic                  xf_valid_q, xf_end_q;

  logic [DW:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, push, pop, drop;
  logic [DW:0]     head;

  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;
  logic            out_end_q, out_end_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_load;

  // The first pixel of a frame is transformed with the live cfg, which is latched alongside.
  assign mode_eff = (state_q == S_IDLE) ? cfg_mode : mode_q;
  assign off_eff  = (state_q == S_IDLE) ? cfg_offset : off_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    off_d   = off_q;
    fcnt_d  = fcnt_q;
    if (image_pipe_valid_in) begin
      case (state_q)
        S_IDLE: begin
          mode_d = cfg_mode;
          off_d  = cfg_offset;
          if (!image_pipe_end_in) state_d = S_IN_FRAME;
        end
        default: begin
          if (image_pipe_end_in) state_d = S_IDLE;
        end
      endcase
      if (image_pipe_end_in) fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  always_comb begin
    xf_data_d = '0;
    ch        = '0;
    sum       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch  = image_pipe_data_in[k*CH_W +: CH_W];
      sum = $signed({2'b00, ch}) + $signed({off_eff[CH_W], off_eff});
      case (mode_eff)
        2'd0: xf_data_d[k*CH_W +: CH_W] = ch;
        2'd1: xf_data_d[k*CH_W +: CH_W] = MAXV - ch;
        2'd2: begin
          if (sum[CH_W+1])
            xf_data_d[k*CH_W +: CH_W] = '0;
          else if (sum > $signed({2'b00, MAXV}))
            xf_data_d[k*CH_W +: CH_W] = MAXV;
          else
            xf_data_d[k*CH_W +: CH_W] = sum[CH_W-1:0];
        end
        default: xf_data_d[k*CH_W +: CH_W] = image_pipe_data_in[(NUM_CH-1-k)*CH_W +: CH_W];
      endcase
    end
  end

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign head     = mem[rd_ptr_q];
  assign out_load = !out_valid_q || !ipm_busy_in;
  assign pop      = out_load && !empty;
  // A pop in the same cycle frees the slot, so a push on a full FIFO is kept.
  assign push     = xf_valid_q && (!full || pop);
  assign drop     = xf_valid_q && full && !pop;

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    busy_d      = (CW'(DEPTH) - count_q) <= CW'(BUSY_MARGIN);
    ovf_d       = ovf_q;
    if (drop)    ovf_d = 1'b1;
    if (ovf_clr) ovf_d = 1'b0;
    out_valid_d = out_valid_q;
    out_end_d   = out_end_q;
    out_data_d  = out_data_q;
    if (out_load) begin
      if (!empty) begin
        out_valid_d = 1'b1;
        out_end_d   = head[DW];
        out_data_d  = head[DW-1:0];
      end else begin
        out_valid_d = 1'b0;
        out_end_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      off_q       <= '0;
      fcnt_q      <= '0;
      xf_valid_q  <= 1'b0;
      xf_end_q    <= 1'b0;
      xf_data_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_end_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      off_q       <= off_d;
      fcnt_q      <= fcnt_d;
      xf_valid_q  <= image_pipe_valid_in;
      xf_end_q    <= image_pipe_valid_in && image_pipe_end_in;
      xf_data_q   <= xf_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_end_q   <= out_end_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {xf_end_q, xf_data_q};
  end

  assign image_pipe_busy_out = busy_q;
  assign ipm_valid_out       = out_valid_q;
  assign ipm_end_out         = out_end_q;
  assign ipm_data_out        = out_data_q;
  assign frame_cnt           = fcnt_q;
  assign ovf_sticky          = ovf_q;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_image_pipe_xform_fifo.sv
// Directed bench for image_pipe_xform_fifo: transform vector table plus frame,
// backpressure/overflow and mid-frame reset sequences checked against an expected queue.
module tb_image_pipe_xform_fifo;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 8;
  localparam int DW     = NUM_CH * CH_W;
  localparam int FCNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     data_in;
  logic              valid_in, end_in;
  logic              busy_out;
  logic [DW-1:0]     data_out;
  logic              valid_out, end_out;
  logic              busy_in;
  logic [1:0]        cfg_mode;
  logic [CH_W:0]     cfg_offset;
  logic [FCNT_W-1:0] frame_cnt;
  logic              ovf_sticky, ovf_clr;
  logic              dbg_state;

  image_pipe_xform_fifo #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DEPTH(16), .BUSY_MARGIN(2), .FCNT_W(FCNT_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .image_pipe_data_in  (data_in),
    .image_pipe_valid_in (valid_in),
    .image_pipe_end_in   (end_in),
    .image_pipe_busy_out (busy_out),
    .ipm_data_out        (data_out),
    .ipm_valid_out       (valid_out),
    .ipm_end_out         (end_out),
    .ipm_busy_in         (busy_in),
    .cfg_mode            (cfg_mode),
    .cfg_offset          (cfg_offset),
    .frame_cnt           (frame_cnt),
    .ovf_sticky          (ovf_sticky),
    .ovf_clr             (ovf_clr),
    .dbg_state_o         (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;
  logic [DW:0] exp_q[$];

  typedef struct {
    logic [1:0]    mode;
    logic [CH_W:0] offset;
    logic [DW-1:0] din;
    logic [DW-1:0] dexp;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drivers: inputs change #1 after posedge; each send occupies exactly one edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic e);
    data_in  = d;
    end_in   = e;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    end_in   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: a transfer is decided on the coming posedge; inputs are stable at negedge.
  always @(negedge clk) begin
    if (!rst && mon_en && valid_out && !busy_in) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got %0h end %0b, expected nothing", data_out, end_out);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        if ({end_out, data_out} !== e) begin
          n_fail++;
          $display("FAIL out_stream: got end %0b data %0h expected end %0b data %0h",
                   end_out, data_out, e[DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 9'h000, 32'h12345678, 32'h12345678};
    vecs[1] = '{2'd1, 9'h000, 32'h00FF1234, 32'hFF00EDCB};
    vecs[2] = '{2'd2, 9'h0C8, 32'h1080FF00, 32'hD8FFFFC8};
    vecs[3] = '{2'd2, 9'h1E0, 32'h1080FF00, 32'h0060DF00};
    vecs[4] = '{2'd3, 9'h000, 32'h11223344, 32'h44332211};
    vecs[5] = '{2'd2, 9'h0FF, 32'h00000001, 32'hFFFFFFFF};
    vecs[6] = '{2'd2, 9'h100, 32'hFFFFFFFF, 32'h00000000};
    vecs[7] = '{2'd1, 9'h000, 32'h00000000, 32'hFFFFFFFF};

    rst = 1'b1; data_in = '0; valid_in = 1'b0; end_in = 1'b0; busy_in = 1'b0;
    cfg_mode = 2'd0; cfg_offset = '0; ovf_clr = 1'b0;
    tick(3);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_fcnt", 64'(frame_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf_sticky), 64'd0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_end", 64'(end_out), 64'd0);
    chk("post_rst_state", 64'(dbg_state), 64'd0);

    // Transform table: single-pixel frames, two-edge latency, idle afterwards
    for (int i = 0; i < 8; i++) begin
      cfg_mode   = vecs[i].mode;
      cfg_offset = vecs[i].offset;
      send(vecs[i].din, 1'b1);
      tick(1);
      chk("vec_latency_early", 64'(valid_out), 64'd0);
      tick(1);
      chk("vec_valid", 64'(valid_out), 64'd1);
      chk("vec_data", 64'(data_out), 64'(vecs[i].dexp));
      chk("vec_end", 64'(end_out), 64'd1);
      tick(1);
      chk("vec_idle", 64'(valid_out), 64'd0);
    end
    chk("vec_fcnt", 64'(frame_cnt), 64'd8);

    // Mode 0, 8-pixel frame
    mon_en   = 1'b1;
    cfg_mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] d;
      d = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      exp_q.push_back({(i == 7), d});
      send(d, (i == 7));
      if (i == 3) chk("frame_state_in", 64'(dbg_state), 64'd1);
    end
    chk("frame_state_idle", 64'(dbg_state), 64'd0);
    chk("frame_fcnt", 64'(frame_cnt), 64'd9);
    wait_drain("frame_drain");

    // Mode switch mid-frame: frame A stays inverted, frame B is channel-reversed
    cfg_mode = 2'd1;
    exp_q.push_back({1'b0, 32'hFEFDFCFB}); send(32'h01020304, 1'b0);
    exp_q.push_back({1'b0, 32'hFAF9F8F7}); send(32'h05060708, 1'b0);
    cfg_mode = 2'd3;
    exp_q.push_back({1'b0, 32'hF6F5F4F3}); send(32'h090A0B0C, 1'b0);
    exp_q.push_back({1'b1, 32'hF2F1F0EF}); send(32'h0D0E0F10, 1'b1);
    exp_q.push_back({1'b0, 32'h44332211}); send(32'h11223344, 1'b0);
    exp_q.push_back({1'b1, 32'hD0C0B0A0}); send(32'hA0B0C0D0, 1'b1);
    wait_drain("switch_drain");
    chk("switch_fcnt", 64'(frame_cnt), 64'd11);

    // Back-to-back single-pixel frames
    cfg_mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, 32'hAAAA0001 + 32'(i)});
      send(32'hAAAA0001 + 32'(i), 1'b1);
    end
    wait_drain("single_drain");
    chk("single_fcnt", 64'(frame_cnt), 64'd14);
    chk("single_state", 64'(dbg_state), 64'd0);
    tick(3);

    // Backpressure: 20-pixel stream against a stalled output; pixels 17..19 drop
    busy_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k <= 16) exp_q.push_back({1'b0, 32'hC0DE0000 + 32'(k)});
      send(32'hC0DE0000 + 32'(k), (k == 19));
      if (k == 15) chk("bp_busy_low", 64'(busy_out), 64'd0);
      if (k == 16) chk("bp_busy_high", 64'(busy_out), 64'd1);
      if (k == 17) chk("bp_ovf_before", 64'(ovf_sticky), 64'd0);
      if (k == 18) chk("bp_ovf_set", 64'(ovf_sticky), 64'd1);
    end
    chk("bp_hold_valid", 64'(valid_out), 64'd1);
    chk("bp_hold_data", 64'(data_out), 64'hC0DE0000);
    chk("bp_fcnt", 64'(frame_cnt), 64'd15);
    tick(2);
    chk("bp_hold_data2", 64'(data_out), 64'hC0DE0000);
    busy_in = 1'b0;
    wait_drain("bp_drain");
    tick(3);
    chk("bp_busy_release", 64'(busy_out), 64'd0);
    chk("bp_ovf_kept", 64'(ovf_sticky), 64'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("bp_ovf_clr", 64'(ovf_sticky), 64'd0);

    // Reset mid-frame with 5 entries queued behind a stalled output
    busy_in = 1'b1;
    for (int k = 0; k < 6; k++) send(32'hBEEF0000 + 32'(k), 1'b0);
    tick(2);
    chk("mrst_pre_valid", 64'(valid_out), 64'd1);
    chk("mrst_pre_state", 64'(dbg_state), 64'd1);
    rst = 1'b1;
    #1;
    chk("mrst_valid", 64'(valid_out), 64'd0);
    chk("mrst_busy", 64'(busy_out), 64'd0);
    chk("mrst_data", 64'(data_out), 64'd0);
    chk("mrst_fcnt", 64'(frame_cnt), 64'd0);
    chk("mrst_state", 64'(dbg_state), 64'd0);
    tick(1);
    rst = 1'b0;
    busy_in = 1'b0;
    cfg_mode = 2'd1;
    exp_q.push_back({1'b0, 32'hFEFDFCFB}); send(32'h01020304, 1'b0);
    cfg_mode = 2'd0;
    exp_q.push_back({1'b1, 32'hEFDFCFBF}); send(32'h10203040, 1'b1);
    wait_drain("mrst_drain");
    tick(3);
    chk("mrst_fcnt_after", 64'(frame_cnt), 64'd1);
    chk("mrst_idle", 64'(valid_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
